// File: rtl/adpcm_pkg.sv
// Shared ADPCM constants and helpers: Dialogic step table, index bounds,
// and the step-index adjustment rule (common to decoder and encoder).
package adpcm_pkg;

  localparam int IDX_W   = 6;
  localparam int STEP_W  = 11;
  localparam int IDX_MAX = 48;

  localparam logic [STEP_W-1:0] STEP_TBL [0:IDX_MAX] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  // Step size for an index; indices past the table end read the last entry.
  function automatic logic [STEP_W-1:0] step_lookup(input logic [IDX_W-1:0] idx);
    if (idx > IDX_W'(IDX_MAX)) begin
      step_lookup = STEP_TBL[IDX_MAX];
    end else begin
      step_lookup = STEP_TBL[idx];
    end
  endfunction

  // Index adjustment from the code magnitude: small codes shrink the step.
  function automatic logic signed [4:0] idx_delta(input logic [2:0] mag);
    case (mag)
      3'd4:    idx_delta = 5'sd2;
      3'd5:    idx_delta = 5'sd4;
      3'd6:    idx_delta = 5'sd6;
      3'd7:    idx_delta = 5'sd8;
      default: idx_delta = -5'sd1;
    endcase
  endfunction

endpackage

// File: rtl/adpcm_core.sv
// Combinational single-nibble ADPCM decode step:
// (old index, old estimate, code) -> (new index, new saturated estimate).
module adpcm_core
  import adpcm_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic [SAMPLE_W-1:0] est,
  input  logic [3:0]          code,
  output logic [IDX_W-1:0]    idx_new,
  output logic [SAMPLE_W-1:0] est_new
);

  // Two guard bits so est +/- d cannot wrap before saturation.
  localparam int XW = SAMPLE_W + 2;
  localparam logic signed [XW-1:0] SAT_MAX = {{3{1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {{3{1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic [XW-1:0]        ss_s;
  logic [XW-1:0]        d_s;
  logic signed [XW-1:0] est_ext_s;
  logic signed [XW-1:0] x_s;
  logic signed [4:0]    delta_s;
  logic signed [7:0]    idx_sum_s;

  // Difference magnitude from the scaled step, then signed add and saturation.
  always_comb begin
    ss_s      = {{(XW-STEP_W){1'b0}}, step_lookup(idx)} << (SAMPLE_W-12);
    d_s       = (code[2] ? ss_s : {XW{1'b0}})
              + (code[1] ? (ss_s >> 1) : {XW{1'b0}})
              + (code[0] ? (ss_s >> 2) : {XW{1'b0}})
              + (ss_s >> 3);
    est_ext_s = {{2{est[SAMPLE_W-1]}}, est};
    x_s       = code[3] ? (est_ext_s - $signed(d_s)) : (est_ext_s + $signed(d_s));
    if (x_s > SAT_MAX) begin
      est_new = SAT_MAX[SAMPLE_W-1:0];
    end else if (x_s < SAT_MIN) begin
      est_new = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      est_new = x_s[SAMPLE_W-1:0];
    end
  end

  // Step-index adaptation from the old index, clamped to the table range.
  always_comb begin
    delta_s   = idx_delta(code[2:0]);
    idx_sum_s = $signed({2'b00, idx}) + $signed({{3{delta_s[4]}}, delta_s});
    if (idx_sum_s < 8'sd0) begin
      idx_new = {IDX_W{1'b0}};
    end else if (idx_sum_s > 8'(IDX_MAX)) begin
      idx_new = IDX_W'(IDX_MAX);
    end else begin
      idx_new = idx_sum_s[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/adpcm_decoder_mc.sv
// Multi-channel Dialogic ADPCM decoder: per-channel index/estimate flops,
// one shared decode core, single-entry output register with valid/ready.
module adpcm_decoder_mc
  import adpcm_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 12,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_code,
  input  logic [CH_W-1:0]     in_chan,
  input  logic                clr_valid,
  input  logic [CH_W-1:0]     clr_chan,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic [CH_W-1:0]     out_chan
);

  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CHANNELS);

  logic [IDX_W-1:0]    idx_r [CHANNELS];
  logic [SAMPLE_W-1:0] est_r [CHANNELS];
  logic                out_valid_r;
  logic [SAMPLE_W-1:0] out_sample_r;
  logic [CH_W-1:0]     out_chan_r;

  logic                accept_s;
  logic                in_ok_s;
  logic                clr_ok_s;
  logic [IDX_W-1:0]    cur_idx_s;
  logic [SAMPLE_W-1:0] cur_est_s;
  logic [IDX_W-1:0]    new_idx_s;
  logic [SAMPLE_W-1:0] new_est_s;

  assign in_ready   = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready;
  assign in_ok_s    = ({1'b0, in_chan} < CH_LIM);
  assign clr_ok_s   = clr_valid && ({1'b0, clr_chan} < CH_LIM);
  assign out_valid  = out_valid_r;
  assign out_sample = out_sample_r;
  assign out_chan   = out_chan_r;

  // Pick the addressed channel's state; a same-cycle clear forces a fresh start.
  always_comb begin
    cur_idx_s = {IDX_W{1'b0}};
    cur_est_s = {SAMPLE_W{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_chan == CH_W'(c)) begin
        cur_idx_s = idx_r[c];
        cur_est_s = est_r[c];
      end else begin
        cur_idx_s = cur_idx_s;
        cur_est_s = cur_est_s;
      end
    end
    if (clr_ok_s && (clr_chan == in_chan)) begin
      cur_idx_s = {IDX_W{1'b0}};
      cur_est_s = {SAMPLE_W{1'b0}};
    end else begin
      cur_idx_s = cur_idx_s;
      cur_est_s = cur_est_s;
    end
  end

  adpcm_core #(
    .SAMPLE_W (SAMPLE_W)
  ) u_core (
    .idx     (cur_idx_s),
    .est     (cur_est_s),
    .code    (in_code),
    .idx_new (new_idx_s),
    .est_new (new_est_s)
  );

  // Per-channel state: decode result wins over a clear (it already saw the clear).
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!reset_n) begin
        idx_r[c] <= {IDX_W{1'b0}};
        est_r[c] <= {SAMPLE_W{1'b0}};
      end else if (accept_s && in_ok_s && (in_chan == CH_W'(c))) begin
        idx_r[c] <= new_idx_s;
        est_r[c] <= new_est_s;
      end else if (clr_ok_s && (clr_chan == CH_W'(c))) begin
        idx_r[c] <= {IDX_W{1'b0}};
        est_r[c] <= {SAMPLE_W{1'b0}};
      end else begin
        idx_r[c] <= idx_r[c];
        est_r[c] <= est_r[c];
      end
    end
  end

  // Output register: load on a valid accept, drain on out_ready, else hold.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_r  <= 1'b0;
      out_sample_r <= {SAMPLE_W{1'b0}};
      out_chan_r   <= {CH_W{1'b0}};
    end else if (accept_s && in_ok_s) begin
      out_valid_r  <= 1'b1;
      out_sample_r <= new_est_s;
      out_chan_r   <= in_chan;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_adpcm_decoder_mc.sv
// Self-checking bench for adpcm_decoder_mc: directed test-plan steps plus a
// randomized phase, checked against an arithmetic reference model.
module tb_adpcm_decoder_mc;

  localparam int CH = 3;
  localparam int SW = 12;
  localparam int CW = 2;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_code;
  logic [CW-1:0] in_chan;
  logic          clr_valid;
  logic [CW-1:0] clr_chan;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sample;
  logic [CW-1:0] out_chan;

  adpcm_decoder_mc #(.CHANNELS(CH), .SAMPLE_W(SW), .CH_W(CW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_chan    (in_chan),
    .clr_valid  (clr_valid),
    .clr_chan   (clr_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_chan   (out_chan)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int tbl [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60,
                   66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209,
                   230, 253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658,
                   724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552};

  int m_idx [CH];
  int m_est [CH];
  int q_s [$];
  int q_c [$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int model_decode(input int c, input int code);
    int ss, d, x, mag;
    mag = code & 7;
    ss  = tbl[m_idx[c]] * (1 << (SW - 12));
    d   = ss / 8;
    if ((mag & 4) != 0) d += ss;
    if ((mag & 2) != 0) d += ss / 2;
    if ((mag & 1) != 0) d += ss / 4;
    x = ((code & 8) != 0) ? m_est[c] - d : m_est[c] + d;
    if (x > (1 << (SW - 1)) - 1) x = (1 << (SW - 1)) - 1;
    if (x < -(1 << (SW - 1)))    x = -(1 << (SW - 1));
    m_est[c] = x;
    m_idx[c] += (mag < 4) ? -1 : 2 * (mag - 3);
    if (m_idx[c] < 0)  m_idx[c] = 0;
    if (m_idx[c] > 48) m_idx[c] = 48;
    return x;
  endfunction

  // One clock cycle: drive, check visible outputs against the model, advance model.
  task automatic step(input bit iv, input int code, input int ch,
                      input bit cv, input int cc, input bit ordy);
    bit exp_rdy;
    int s;
    @(negedge clock);
    in_valid  = iv;
    in_code   = 4'(code);
    in_chan   = CW'(ch);
    clr_valid = cv;
    clr_chan  = CW'(cc);
    out_ready = ordy;
    #1;
    exp_rdy = (q_s.size() == 0) || ordy;
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    chk("out_valid", int'(out_valid), (q_s.size() > 0) ? 1 : 0);
    if (q_s.size() > 0) begin
      chk("out_sample", int'($signed(out_sample)), q_s[0]);
      chk("out_chan", int'(out_chan), q_c[0]);
      if (ordy) begin
        void'(q_s.pop_front());
        void'(q_c.pop_front());
      end
    end
    if (cv && cc < CH) begin
      m_idx[cc] = 0;
      m_est[cc] = 0;
    end
    if (iv && exp_rdy && ch < CH) begin
      s = model_decode(ch, code);
      q_s.push_back(s);
      q_c.push_back(ch);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    clr_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    for (int c = 0; c < CH; c++) begin
      m_idx[c] = 0;
      m_est[c] = 0;
    end
    q_s.delete();
    q_c.delete();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sample", int'(out_sample), 0);
    chk("rst_out_chan", int'(out_chan), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  int sat_seq [6] = '{30, 93, 229, 522, 1153, 2047};

  initial begin
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_code   = 4'd0;
    in_chan   = '0;
    clr_valid = 1'b0;
    clr_chan  = '0;
    out_ready = 1'b1;

    // Basic decode and index adaptation on ch0.
    do_reset();
    step(1, 7, 0, 0, 0, 1);
    chk("tp_ch0_7", int'($signed(out_sample)), 30);
    step(1, 0, 0, 0, 0, 1);
    chk("tp_ch0_0", int'($signed(out_sample)), 34);
    step(0, 0, 0, 0, 0, 1);

    // Lower index clamp on ch1, interleaved with ch0.
    do_reset();
    step(1, 7, 0, 0, 0, 1);
    step(1, 8, 1, 0, 0, 1);
    chk("tp_ch1_neg", int'($signed(out_sample)), -2);
    step(1, 0, 0, 0, 0, 1);
    chk("tp_ch0_interleave", int'($signed(out_sample)), 34);
    step(1, 8, 1, 0, 0, 1);
    chk("tp_ch1_clamp", int'($signed(out_sample)), -4);
    step(0, 0, 0, 0, 0, 1);

    // Upper saturation with back-to-back nibbles.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 7, 0, 0, 0, 1);
      chk($sformatf("tp_sat_%0d", i), int'($signed(out_sample)), sat_seq[i]);
    end
    step(0, 0, 0, 0, 0, 1);

    // Backpressure: hold out_ready low with a nibble waiting.
    do_reset();
    step(1, 7, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 8, 1, 0, 0, 0);
      chk("bp_hold", int'($signed(out_sample)), 30);
    end
    step(1, 8, 1, 0, 0, 1);
    chk("bp_release", int'($signed(out_sample)), -2);
    step(0, 0, 0, 0, 0, 1);

    // Coincident clear while ch0 est is 1153, then an out-of-range tag.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 7, 0, 0, 0, 1);
    chk("clr_pre", int'($signed(out_sample)), 1153);
    step(1, 7, 0, 1, 0, 1);
    chk("clr_coincide", int'($signed(out_sample)), 30);
    step(1, 7, 3, 1, 3, 1);
    chk("oor_drop", int'(out_valid), 0);
    step(1, 7, 0, 0, 0, 1);
    chk("after_oor", int'($signed(out_sample)), 93);
    step(0, 0, 0, 0, 0, 1);

    // Reset mid-stream with a pending output.
    step(1, 3, 1, 0, 0, 0);
    do_reset();
    step(1, 7, 0, 0, 0, 1);
    chk("post_rst", int'($signed(out_sample)), 30);
    step(0, 0, 0, 0, 0, 1);

    // Randomized traffic across valid and invalid tags, clears and backpressure.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)), bit'($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 3)), bit'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
